// File: rtl/main_ctrl_fsm.sv
// Multicycle main control FSM for the RISC-V core: sequences fetch/decode/
// execute/memory/writeback and drives the datapath mux selects and enables.
module main_ctrl_fsm #(
  parameter int unsigned OPW = 7
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [OPW-1:0] op,
  input  logic           zero,
  input  logic           mem_ready,
  output logic [1:0]     alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     result_src,
  output logic           adr_src,
  output logic [1:0]     alu_op,
  output logic           ir_write,
  output logic           pc_write,
  output logic           reg_write,
  output logic           mem_write,
  output logic           illegal_instr
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, AUIPC, ILLEGAL
  } state_e;

  localparam logic [OPW-1:0] OP_LW    = OPW'(7'b0000011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(7'b0100011);
  localparam logic [OPW-1:0] OP_R     = OPW'(7'b0110011);
  localparam logic [OPW-1:0] OP_I     = OPW'(7'b0010011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(7'b1100011);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(7'b1101111);
  localparam logic [OPW-1:0] OP_AUIPC = OPW'(7'b0010111);

  state_e state_q, state_d;
  logic   pc_update, branch, ir_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        if (op == OP_LW || op == OP_SW) state_d = MEMADR;
        else if (op == OP_R)            state_d = EXECR;
        else if (op == OP_I)            state_d = EXECI;
        else if (op == OP_BEQ)          state_d = BEQ;
        else if (op == OP_JAL)          state_d = JAL;
        else if (op == OP_AUIPC)        state_d = AUIPC;
        else                            state_d = ILLEGAL;
      end
      MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
      AUIPC:    state_d = ALUWB;
      ILLEGAL:  state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // Outputs decode straight from state_q so an async reset drops them at once.
  always_comb begin
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    adr_src       = 1'b0;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    illegal_instr = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_en         = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_en      = mem_ready;
        pc_update  = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB:    reg_write = 1'b1;
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      ILLEGAL:  illegal_instr = 1'b1;
      default: ;
    endcase
    ir_write = ir_en & reset_n;
    pc_write = (pc_update | (branch & zero)) & reset_n;
  end

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Directed-vector bench for main_ctrl_fsm: the driver queues the expected
// control word for each cycle, a negedge monitor pops and compares it.
module tb_main_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = 7'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic       adr_src, ir_write, pc_write, reg_write, mem_write, illegal_instr;

  main_ctrl_fsm #(.OPW(7)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .adr_src(adr_src), .alu_op(alu_op), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .mem_write(mem_write), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] a, b, res;
    logic       adr;
    logic [1:0] aop;
    logic       ir, pcw, rw, mw, ill;
  } ctl_t;

  typedef enum {P_RST, P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI,
                P_AWB, P_BEQ, P_JAL, P_AUI, P_ILL} ph_t;

  typedef struct {
    ph_t  ph;
    ctl_t e;
  } item_t;

  item_t q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  bit done = 1'b0;

  // Hand-written control word for each phase of an instruction.
  function automatic ctl_t exp_of(ph_t p, logic mr, logic z);
    ctl_t e = '0;
    case (p)
      P_RST: begin e.b = 2'b10; e.res = 2'b10; end
      P_F:   begin e.b = 2'b10; e.res = 2'b10; e.ir = mr; e.pcw = mr; end
      P_D:   begin e.a = 2'b01; e.b = 2'b01; end
      P_MA:  begin e.a = 2'b10; e.b = 2'b01; end
      P_MR:  e.adr = 1'b1;
      P_MWB: begin e.res = 2'b01; e.rw = 1'b1; end
      P_MW:  begin e.adr = 1'b1; e.mw = 1'b1; end
      P_ER:  begin e.a = 2'b10; e.aop = 2'b10; end
      P_EI:  begin e.a = 2'b10; e.b = 2'b01; e.aop = 2'b10; end
      P_AWB: e.rw = 1'b1;
      P_BEQ: begin e.a = 2'b10; e.aop = 2'b01; e.pcw = z; end
      P_JAL: begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; end
      P_AUI: begin e.a = 2'b01; e.b = 2'b01; end
      P_ILL: e.ill = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic cyc(ph_t p, logic mr, logic z, logic rn);
    item_t it;
    @(posedge clk);
    #1;
    reset_n   = rn;
    mem_ready = mr;
    zero      = z;
    it.ph = p;
    it.e  = exp_of(p, mr, z);
    q.push_back(it);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      ctl_t  act;
      it  = q.pop_front();
      act = '{a: alu_src_a, b: alu_src_b, res: result_src, adr: adr_src,
              aop: alu_op, ir: ir_write, pcw: pc_write, rw: reg_write,
              mw: mem_write, ill: illegal_instr};
      n_vec++;
      if (act !== it.e) begin
        n_bad++;
        $display("FAIL %s @%0t: got %b required %b", it.ph.name(), $time, act, it.e);
      end
    end
  end

  initial begin
    // Reset held: FETCH outputs with ir_write/pc_write suppressed.
    cyc(P_RST, 1'b1, 1'b1, 1'b0);
    cyc(P_F, 1'b1, 1'b0, 1'b1);

    op = 7'b0000011;  // lw
    cyc(P_D, 1'b1, 1'b1, 1'b1);
    cyc(P_MA, 1'b1, 1'b1, 1'b1);
    cyc(P_MR, 1'b1, 1'b1, 1'b1);
    cyc(P_MWB, 1'b1, 1'b1, 1'b1);

    op = 7'b0100011;  // sw with 3 wait cycles
    cyc(P_F, 1'b1, 1'b0, 1'b1);
    cyc(P_D, 1'b1, 1'b0, 1'b1);
    cyc(P_MA, 1'b1, 1'b0, 1'b1);
    cyc(P_MW, 1'b0, 1'b0, 1'b1);
    cyc(P_MW, 1'b0, 1'b1, 1'b1);
    cyc(P_MW, 1'b0, 1'b0, 1'b1);
    cyc(P_MW, 1'b1, 1'b0, 1'b1);

    op = 7'b0110011;  // R-type
    cyc(P_F, 1'b1, 1'b1, 1'b1);
    cyc(P_D, 1'b1, 1'b1, 1'b1);
    cyc(P_ER, 1'b1, 1'b1, 1'b1);
    cyc(P_AWB, 1'b1, 1'b1, 1'b1);

    op = 7'b0010011;  // I-type, with a fetch stall first
    cyc(P_F, 1'b0, 1'b1, 1'b1);
    cyc(P_F, 1'b0, 1'b0, 1'b1);
    cyc(P_F, 1'b1, 1'b0, 1'b1);
    cyc(P_D, 1'b1, 1'b0, 1'b1);
    cyc(P_EI, 1'b1, 1'b1, 1'b1);
    cyc(P_AWB, 1'b1, 1'b0, 1'b1);

    op = 7'b0010111;  // auipc
    cyc(P_F, 1'b1, 1'b0, 1'b1);
    cyc(P_D, 1'b1, 1'b0, 1'b1);
    cyc(P_AUI, 1'b1, 1'b1, 1'b1);
    cyc(P_AWB, 1'b1, 1'b0, 1'b1);

    op = 7'b1100011;  // beq taken, then not taken
    cyc(P_F, 1'b1, 1'b0, 1'b1);
    cyc(P_D, 1'b1, 1'b1, 1'b1);
    cyc(P_BEQ, 1'b1, 1'b1, 1'b1);
    cyc(P_F, 1'b1, 1'b0, 1'b1);
    cyc(P_D, 1'b1, 1'b1, 1'b1);
    cyc(P_BEQ, 1'b1, 1'b0, 1'b1);

    op = 7'b1101111;  // jal
    cyc(P_F, 1'b1, 1'b0, 1'b1);
    cyc(P_D, 1'b1, 1'b0, 1'b1);
    cyc(P_JAL, 1'b1, 1'b0, 1'b1);
    cyc(P_AWB, 1'b1, 1'b1, 1'b1);

    op = 7'b1111111;  // illegal
    cyc(P_F, 1'b1, 1'b0, 1'b1);
    cyc(P_D, 1'b1, 1'b0, 1'b1);
    cyc(P_ILL, 1'b1, 1'b1, 1'b1);

    op = 7'b0100011;  // sw abandoned by reset mid-MEMWRITE
    cyc(P_F, 1'b1, 1'b0, 1'b1);
    cyc(P_D, 1'b1, 1'b0, 1'b1);
    cyc(P_MA, 1'b1, 1'b0, 1'b1);
    cyc(P_MW, 1'b0, 1'b0, 1'b1);
    cyc(P_RST, 1'b1, 1'b1, 1'b0);
    op = 7'b0110011;
    cyc(P_F, 1'b1, 1'b0, 1'b1);
    cyc(P_D, 1'b1, 1'b0, 1'b1);
    cyc(P_ER, 1'b1, 1'b0, 1'b1);
    cyc(P_AWB, 1'b1, 1'b0, 1'b1);
    cyc(P_F, 1'b1, 1'b0, 1'b1);
    done = 1'b1;
  end

  initial begin
    wait (done);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, required completion");
    $fatal(1);
  end

endmodule
